leaf_uplink_port: RTL and testbench

- Leaf-side end of a spine↔leaf link. It sources the flit stream that a spine leaf port ingests and sinks the flit stream that port emits.
- TX path: buffers local flits and paces them onto the uplink using credits returned by the spine.
- RX path: filters downlink flits by destination address, buffers accepted flits for the local leaf crossbar, and returns credits upstream for every downlink flit consumed or dropped.
- One instance per leaf per spine link.

---
 rtl/leaf_uplink_port.sv | 156 +++++++++++++++
 tb/tb_leaf_uplink_port.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/leaf_uplink_port.sv
// Leaf-side end of a spine<->leaf link.
// TX: buffers local flits and paces them onto the uplink against spine credits.
// RX: filters downlink flits by group/leaf address, buffers matches for the
//     local crossbar, and returns one credit per downlink flit popped or dropped.
module leaf_uplink_port #(
  parameter logic [3:0] GROUP_ID    = 4'b0111,
  parameter logic [1:0] LEAF_ID     = 2'd0,
  parameter int         DWIDTH      = 16,
  parameter int         FIFO_DEPTH  = 8,
  parameter int         CREDIT_INIT = 8,
  localparam int        CW          = $clog2(CREDIT_INIT + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DWIDTH-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic [DWIDTH-1:0] up_data,
  output logic              up_valid,
  input  logic              credit_in,
  input  logic [DWIDTH-1:0] dn_data,
  input  logic              dn_valid,
  output logic [1:0]        credit_out,
  output logic [DWIDTH-1:0] rx_data,
  output logic              rx_valid,
  input  logic              rx_ready,
  output logic [CW-1:0]     credits,
  output logic [7:0]        drop_cnt,
  output logic [7:0]        ovf_cnt,
  output logic              credit_err
);

  localparam int             AW      = $clog2(FIFO_DEPTH);
  localparam int             NW      = AW + 1;
  localparam logic [NW-1:0]  DEPTH_N = NW'(FIFO_DEPTH);
  localparam logic [CW-1:0]  CINIT   = CW'(CREDIT_INIT);

  logic [DWIDTH-1:0] tx_mem [FIFO_DEPTH];
  logic [DWIDTH-1:0] rx_mem [FIFO_DEPTH];

  logic [AW-1:0]     tx_wr_q, tx_wr_d, tx_rd_q, tx_rd_d;
  logic [AW-1:0]     rx_wr_q, rx_wr_d, rx_rd_q, rx_rd_d;
  logic [NW-1:0]     tx_cnt_q, tx_cnt_d, rx_cnt_q, rx_cnt_d;
  logic [CW-1:0]     credits_q, credits_d;
  logic [DWIDTH-1:0] up_data_q, up_data_d;
  logic              up_valid_q, up_valid_d;
  logic [1:0]        credit_out_q, credit_out_d;
  logic [7:0]        drop_q, drop_d, ovf_q, ovf_d;
  logic              credit_err_q, credit_err_d;

  logic tx_push, tx_send, credit_ok;
  logic dn_match, rx_full, rx_pop, rx_push, drop_mis, drop_ovf;

  // Handshake and classification terms derived from current occupancy.
  always_comb begin
    tx_push   = tx_valid && tx_ready;
    tx_send   = (tx_cnt_q != '0) && (credits_q != '0);
    credit_ok = credit_in && (credits_q != CINIT);
    dn_match  = (dn_data[15:12] == GROUP_ID) && (dn_data[11:10] == LEAF_ID);
    rx_full   = (rx_cnt_q == DEPTH_N);
    rx_pop    = (rx_cnt_q != '0) && rx_ready;
    rx_push   = dn_valid && dn_match && (!rx_full || rx_pop);
    drop_mis  = dn_valid && !dn_match;
    drop_ovf  = dn_valid && dn_match && rx_full && !rx_pop;
  end

  // Next-state computation for pointers, counts, credits and status counters.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    tx_wr_d      = tx_wr_q;
    tx_rd_d      = tx_rd_q;
    tx_cnt_d     = tx_cnt_q;
    rx_wr_d      = rx_wr_q;
    rx_rd_d      = rx_rd_q;
    rx_cnt_d     = rx_cnt_q;
    credits_d    = credits_q;
    up_data_d    = up_data_q;
    up_valid_d   = tx_send;
    credit_err_d = credit_err_q | (credit_in && (credits_q == CINIT));
    credit_out_d = {1'b0, rx_pop} + {1'b0, drop_mis | drop_ovf};
    drop_d       = drop_q;
    ovf_d        = ovf_q;

    if (tx_push) tx_wr_d = tx_wr_q + AW'(1);
    if (tx_send) begin
      tx_rd_d   = tx_rd_q + AW'(1);
      up_data_d = tx_mem[tx_rd_q];
    end
    if (tx_push && !tx_send)      tx_cnt_d = tx_cnt_q + NW'(1);
    else if (!tx_push && tx_send) tx_cnt_d = tx_cnt_q - NW'(1);

    if (credit_ok && !tx_send)      credits_d = credits_q + CW'(1);
    else if (!credit_ok && tx_send) credits_d = credits_q - CW'(1);

    if (rx_push) rx_wr_d = rx_wr_q + AW'(1);
    if (rx_pop)  rx_rd_d = rx_rd_q + AW'(1);
    if (rx_push && !rx_pop)      rx_cnt_d = rx_cnt_q + NW'(1);
    else if (!rx_push && rx_pop) rx_cnt_d = rx_cnt_q - NW'(1);

    if (drop_mis && (drop_q != 8'hFF)) drop_d = drop_q + 8'd1;
    if (drop_ovf && (ovf_q  != 8'hFF)) ovf_d  = ovf_q  + 8'd1;
  end

  // FIFO storage; contents are don't-care until the pointers say otherwise.
  always_ff @(posedge clk) begin
    // NOTE: storage arrays are deliberately not reset; pointers and counts define validity.
    if (tx_push) tx_mem[tx_wr_q] <= tx_data;
    if (rx_push) rx_mem[rx_wr_q] <= dn_data;
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    if (reset) begin
      tx_wr_q      <= '0;
      tx_rd_q      <= '0;
      tx_cnt_q     <= '0;
      rx_wr_q      <= '0;
      rx_rd_q      <= '0;
      rx_cnt_q     <= '0;
      credits_q    <= CINIT;
      up_data_q    <= '0;
      up_valid_q   <= 1'b0;
      credit_out_q <= 2'd0;
      drop_q       <= 8'd0;
      ovf_q        <= 8'd0;
      credit_err_q <= 1'b0;
    end else begin
      tx_wr_q      <= tx_wr_d;
      tx_rd_q      <= tx_rd_d;
      tx_cnt_q     <= tx_cnt_d;
      rx_wr_q      <= rx_wr_d;
      rx_rd_q      <= rx_rd_d;
      rx_cnt_q     <= rx_cnt_d;
      credits_q    <= credits_d;
      up_data_q    <= up_data_d;
      up_valid_q   <= up_valid_d;
      credit_out_q <= credit_out_d;
      drop_q       <= drop_d;
      ovf_q        <= ovf_d;
      credit_err_q <= credit_err_d;
    end
  end

  assign tx_ready   = (tx_cnt_q != DEPTH_N);
  assign up_data    = up_data_q;
  assign up_valid   = up_valid_q;
  assign credit_out = credit_out_q;
  assign rx_data    = rx_mem[rx_rd_q];
  assign rx_valid   = (rx_cnt_q != '0);
  assign credits    = credits_q;
  assign drop_cnt   = drop_q;
  assign ovf_cnt    = ovf_q;
  assign credit_err = credit_err_q;

endmodule

// File: tb/tb_leaf_uplink_port.sv
// Scoreboard bench for leaf_uplink_port: a queue-based model predicts each
// cycle's status and the uplink / local-pop flit streams; a monitor compares.
module tb_leaf_uplink_port;

  localparam int DW    = 16;
  localparam int DEPTH = 8;
  localparam int CINIT = 8;
  localparam int CW    = $clog2(CINIT + 1);

  logic          clk = 1'b0;
  logic          reset;
  logic [DW-1:0] tx_data, dn_data, up_data, rx_data;
  logic          tx_valid, tx_ready, up_valid, credit_in, dn_valid;
  logic          rx_valid, rx_ready, credit_err;
  logic [1:0]    credit_out;
  logic [CW-1:0] credits;
  logic [7:0]    drop_cnt, ovf_cnt;

  always #5 clk = ~clk;

  leaf_uplink_port #(
    .GROUP_ID(4'd7), .LEAF_ID(2'd1), .DWIDTH(DW),
    .FIFO_DEPTH(DEPTH), .CREDIT_INIT(CINIT)
  ) dut (
    .clk(clk), .reset(reset),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .up_data(up_data), .up_valid(up_valid), .credit_in(credit_in),
    .dn_data(dn_data), .dn_valid(dn_valid), .credit_out(credit_out),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .credits(credits), .drop_cnt(drop_cnt), .ovf_cnt(ovf_cnt),
    .credit_err(credit_err)
  );

  typedef struct {
    bit uv; int co; int cr; int dc; int oc; bit err; bit rv; bit tr;
  } stat_t;

  stat_t         exp_stat[$];
  logic [DW-1:0] exp_up[$];
  logic [DW-1:0] exp_rx[$];

  // Behavioural model state: plain queues and integers.
  logic [DW-1:0] tq[$];
  logic [DW-1:0] rq[$];
  int cr = CINIT, dc = 0, oc = 0;
  bit err = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input bit ok, input string name, input string detail);
    n_cmp++;
    if (!ok) begin
      n_bad++;
      $display("FAIL %s: %s", name, detail);
    end
  endtask

  // Drive one cycle of inputs, then advance the model across the edge.
  task automatic cyc(input bit rst, input bit tv, input logic [DW-1:0] td,
                     input bit ci, input bit dv, input logic [DW-1:0] dd,
                     input bit rr);
    stat_t s;
    bit tx_acc, send, pop, match, full_b, drop;
    reset = rst; tx_valid = tv; tx_data = td; credit_in = ci;
    dn_valid = dv; dn_data = dd; rx_ready = rr;
    @(posedge clk);
    s = '{default: 0};
    if (rst) begin
      tq.delete(); rq.delete(); exp_rx.delete();
      cr = CINIT; dc = 0; oc = 0; err = 1'b0;
    end else begin
      tx_acc = tv && (tq.size() < DEPTH);
      send   = (tq.size() > 0) && (cr > 0);
      s.uv   = send;
      if (send) exp_up.push_back(tq.pop_front());
      if (tx_acc) tq.push_back(td);
      if (ci && cr == CINIT) err = 1'b1;
      else if (ci) cr++;
      if (send) cr--;
      pop    = rr && (rq.size() > 0);
      full_b = (rq.size() == DEPTH);
      match  = (dd[15:12] == 4'd7) && (dd[11:10] == 2'd1);
      if (pop) void'(rq.pop_front());
      drop = 1'b0;
      if (dv) begin
        if (!match) begin
          drop = 1'b1;
          if (dc < 255) dc++;
        end else if (full_b && !pop) begin
          drop = 1'b1;
          if (oc < 255) oc++;
        end else begin
          rq.push_back(dd);
          exp_rx.push_back(dd);
        end
      end
      s.co = int'(pop) + int'(drop);
    end
    s.cr = cr; s.dc = dc; s.oc = oc; s.err = err;
    s.rv = (rq.size() > 0);
    s.tr = (tq.size() < DEPTH);
    exp_stat.push_back(s);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, '0, 1'b0, 1'b0, '0, 1'b0);
  endtask

  // Monitor: compares DUT outputs against the scoreboard on falling edges.
  initial begin
    stat_t         s;
    logic [DW-1:0] d;
    forever begin
      @(negedge clk);
      if (exp_stat.size() > 0) begin
        s = exp_stat.pop_front();
        check(up_valid == s.uv && int'(credit_out) == s.co && int'(credits) == s.cr &&
              int'(drop_cnt) == s.dc && int'(ovf_cnt) == s.oc && credit_err == s.err &&
              rx_valid == s.rv && tx_ready == s.tr, "status",
              $sformatf("t=%0t got uv=%0b co=%0d cr=%0d dc=%0d oc=%0d err=%0b rv=%0b tr=%0b; want uv=%0b co=%0d cr=%0d dc=%0d oc=%0d err=%0b rv=%0b tr=%0b",
                        $time, up_valid, credit_out, credits, drop_cnt, ovf_cnt, credit_err,
                        rx_valid, tx_ready, s.uv, s.co, s.cr, s.dc, s.oc, s.err, s.rv, s.tr));
      end
      if (up_valid === 1'b1) begin
        if (exp_up.size() == 0) check(1'b0, "up_flit", $sformatf("t=%0t got 0x%04h, want none", $time, up_data));
        else begin
          d = exp_up.pop_front();
          check(up_data == d, "up_flit", $sformatf("t=%0t got 0x%04h want 0x%04h", $time, up_data, d));
        end
      end
      if (rx_valid === 1'b1 && rx_ready === 1'b1) begin
        if (exp_rx.size() == 0) check(1'b0, "rx_flit", $sformatf("t=%0t got 0x%04h, want none", $time, rx_data));
        else begin
          d = exp_rx.pop_front();
          check(rx_data == d, "rx_flit", $sformatf("t=%0t got 0x%04h want 0x%04h", $time, rx_data, d));
        end
      end
    end
  end

  // Stimulus: directed scenarios, counter saturation, then randomized traffic.
  initial begin
    logic [DW-1:0] d;
    int            rr_pct;
    cyc(1'b1, 1'b0, '0, 1'b0, 1'b0, '0, 1'b0);
    cyc(1'b1, 1'b0, '0, 1'b0, 1'b0, '0, 1'b0);

    // Ten-flit burst with no returned credits: eight go, two stay buffered.
    for (int i = 1; i <= 10; i++) cyc(1'b0, 1'b1, 16'(i), 1'b0, 1'b0, '0, 1'b0);
    idle(4);
    cyc(1'b0, 1'b0, '0, 1'b1, 1'b0, '0, 1'b0);
    idle(1);
    cyc(1'b0, 1'b0, '0, 1'b1, 1'b0, '0, 1'b0);
    idle(3);
    // Credit return coinciding with a send.
    cyc(1'b0, 1'b0, '0, 1'b1, 1'b0, '0, 1'b0);
    cyc(1'b0, 1'b1, 16'h000B, 1'b0, 1'b0, '0, 1'b0);
    cyc(1'b0, 1'b0, '0, 1'b1, 1'b0, '0, 1'b0);
    idle(3);

    // Matching downlink flit held, then popped.
    cyc(1'b0, 1'b0, '0, 1'b0, 1'b1, 16'h7412, 1'b0);
    idle(2);
    cyc(1'b0, 1'b0, '0, 1'b0, 1'b0, '0, 1'b1);
    idle(2);
    // Wrong group is dropped.
    cyc(1'b0, 1'b0, '0, 1'b0, 1'b1, 16'h3400, 1'b0);
    idle(2);
    // Fill RX, overflow once, then accept alongside a pop.
    for (int i = 0; i < DEPTH; i++) cyc(1'b0, 1'b0, '0, 1'b0, 1'b1, 16'h7400 | 16'(i), 1'b0);
    cyc(1'b0, 1'b0, '0, 1'b0, 1'b1, 16'h7455, 1'b0);
    idle(1);
    cyc(1'b0, 1'b0, '0, 1'b0, 1'b1, 16'h7466, 1'b1);
    idle(1);
    for (int i = 0; i < 10; i++) cyc(1'b0, 1'b0, '0, 1'b0, 1'b0, '0, 1'b1);

    // Refill credits to the limit, then one extra pulse is an error.
    while (cr < CINIT) cyc(1'b0, 1'b0, '0, 1'b1, 1'b0, '0, 1'b0);
    cyc(1'b0, 1'b0, '0, 1'b1, 1'b0, '0, 1'b0);
    idle(2);

    // Misroute counter saturation.
    for (int i = 0; i < 260; i++) cyc(1'b0, 1'b0, '0, 1'b0, 1'b1, 16'h1234, 1'b0);

    // Randomized traffic with a reset in the middle of a burst.
    for (int k = 0; k < 1500; k++) begin
      d = 16'($urandom);
      if ($urandom_range(0, 9) < 7) d[15:10] = 6'b0111_01;
      rr_pct = ((k / 150) % 2 == 1) ? 85 : 25;
      cyc(k == 700, $urandom_range(0, 3) != 0, 16'($urandom),
          (cr < CINIT) && ($urandom_range(0, 1) == 1), $urandom_range(0, 2) != 0, d,
          $urandom_range(0, 99) < rr_pct);
    end

    // Drain both paths.
    for (int i = 0; i < 40; i++) cyc(1'b0, 1'b0, '0, cr < CINIT, 1'b0, '0, 1'b1);
    @(negedge clk);
    #1;
    check(exp_up.size() == 0, "up_drain", $sformatf("%0d uplink flits never seen", exp_up.size()));
    check(exp_rx.size() == 0, "rx_drain", $sformatf("%0d rx flits never popped", exp_rx.size()));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
